// File: rtl/fir_tap_sequencer_if.sv
`default_nettype none
// ============================================================================
// fir_tap_sequencer_if: sample strobe in, RAM/ROM/MAC controls out. Rev 1.0
// ============================================================================
interface fir_tap_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              in_strobe;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] samp_addr;
  logic [ADDR_W-1:0] coef_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              out_strobe;
  logic              overrun;

  modport master (
    output in_strobe,
    input  busy, wr_en, wr_addr, samp_addr, coef_addr,
    input  mac_clr, mac_en, out_strobe, overrun
  );

  modport slave (
    input  in_strobe,
    output busy, wr_en, wr_addr, samp_addr, coef_addr,
    output mac_clr, mac_en, out_strobe, overrun
  );
endinterface
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// fir_tap_sequencer: single-MAC FIR control FSM (write, tap walk, drain). Rev 1.0
// ============================================================================
module fir_tap_sequencer #(
  parameter int NTAPS    = 256,
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 3
) (
  input wire                 clk,
  input wire                 reset,
  fir_tap_sequencer_if.slave bus
);

  localparam int                    c_flush_w    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [ADDR_W-1:0]    c_last_tap   = ADDR_W'(NTAPS - 1);
  localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     k_q, k_d;
  logic [c_flush_w-1:0]  flush_q, flush_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                  busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]     samp_addr_q, samp_addr_d;
  logic [ADDR_W-1:0]     coef_addr_q, coef_addr_d;
  logic                  mac_clr_q, mac_clr_d;
  logic                  mac_en_q, mac_en_d;
  logic                  out_strobe_q, out_strobe_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    flush_d   = flush_q;
    wr_ptr_d  = wr_ptr_q;
    overrun_d = overrun_q | (bus.in_strobe & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (bus.in_strobe) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_RUN;
        k_d     = '0;
      end
      S_RUN: begin
        if (k_q == c_last_tap) begin
          flush_d = c_flush_w'(1);
          state_d = (PIPE_LAT == 0) ? S_DONE : S_FLUSH;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end
      S_FLUSH: begin
        if (flush_q == c_flush_last) state_d = S_DONE;
        else                         flush_d = flush_q + c_flush_w'(1);
      end
      S_DONE: begin
        state_d  = S_IDLE;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    busy_d       = (state_d != S_IDLE);
    wr_en_d      = (state_d == S_LOAD);
    wr_addr_d    = (state_d == S_LOAD) ? wr_ptr_q : wr_addr_q;
    mac_en_d     = (state_d == S_RUN);
    mac_clr_d    = (state_d == S_RUN) && (state_q == S_LOAD);
    coef_addr_d  = mac_en_d ? k_d : coef_addr_q;
    samp_addr_d  = mac_en_d ? (wr_ptr_q - k_d) : samp_addr_q;
    out_strobe_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      flush_q      <= '0;
      wr_ptr_q     <= '0;
      busy_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      samp_addr_q  <= '0;
      coef_addr_q  <= '0;
      mac_clr_q    <= 1'b0;
      mac_en_q     <= 1'b0;
      out_strobe_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      flush_q      <= flush_d;
      wr_ptr_q     <= wr_ptr_d;
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      samp_addr_q  <= samp_addr_d;
      coef_addr_q  <= coef_addr_d;
      mac_clr_q    <= mac_clr_d;
      mac_en_q     <= mac_en_d;
      out_strobe_q <= out_strobe_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.samp_addr  = samp_addr_q;
  assign bus.coef_addr  = coef_addr_q;
  assign bus.mac_clr    = mac_clr_q;
  assign bus.mac_en     = mac_en_q;
  assign bus.out_strobe = out_strobe_q;
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fir_tap_sequencer: directed table, corner sequences and random vs model. Rev 1.0
// ============================================================================
module tb_fir_tap_sequencer;

  localparam int NT    = 8;
  localparam int AW    = 4;
  localparam int PL    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = NT + 2 + PL;

  typedef struct packed {
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] samp;
    logic [AW-1:0] coef;
    logic          mac_clr;
    logic          mac_en;
    logic          out_strobe;
    logic          overrun;
  } outs_t;

  typedef struct {
    logic  in_strobe;
    outs_t exp;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;

  // Reference model: everything derives from the cycle distance to the accepted strobe.
  bit            m_active;
  int            m_start;
  int            m_ptr;
  bit            m_ovr;
  logic [AW-1:0] m_wr, m_samp, m_coef;

  fir_tap_sequencer_if #(.ADDR_W(AW)) bus ();

  fir_tap_sequencer #(
    .NTAPS   (NT),
    .ADDR_W  (AW),
    .PIPE_LAT(PL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(input logic b, input logic we, input logic [AW-1:0] wa,
                               input logic [AW-1:0] sa, input logic [AW-1:0] ca,
                               input logic clr, input logic en, input logic os, input logic ov);
    outs_t o;
    o.busy = b; o.wr_en = we; o.wr_addr = wa; o.samp = sa; o.coef = ca;
    o.mac_clr = clr; o.mac_en = en; o.out_strobe = os; o.overrun = ov;
    return o;
  endfunction

  function automatic outs_t sample_dut();
    outs_t o;
    o.busy = bus.busy; o.wr_en = bus.wr_en; o.wr_addr = bus.wr_addr;
    o.samp = bus.samp_addr; o.coef = bus.coef_addr; o.mac_clr = bus.mac_clr;
    o.mac_en = bus.mac_en; o.out_strobe = bus.out_strobe; o.overrun = bus.overrun;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (time %0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_start = 0; m_ptr = 0; m_ovr = 1'b0;
    m_wr = '0; m_samp = '0; m_coef = '0;
  endtask

  task automatic model_expect(output outs_t e);
    int d;
    int j;
    e = '0;
    if (m_active) begin
      d = cyc - m_start;
      e.busy = 1'b1;
      if (d == 1) m_wr = AW'(m_ptr);
      if (d >= 2 && d <= NT + 1) begin
        j = d - 2;
        e.mac_en  = 1'b1;
        e.mac_clr = (j == 0);
        m_coef    = AW'(j);
        m_samp    = AW'((m_ptr - j + DEPTH) % DEPTH);
      end
      e.wr_en      = (d == 1);
      e.out_strobe = (d == LAT);
    end
    e.wr_addr = m_wr;
    e.samp    = m_samp;
    e.coef    = m_coef;
    e.overrun = m_ovr;
  endtask

  task automatic model_advance(input logic s);
    if (m_active) begin
      if (s) m_ovr = 1'b1;
      if (cyc - m_start == LAT) begin
        m_active = 1'b0;
        m_ptr    = (m_ptr + 1) % DEPTH;
      end
    end else if (s) begin
      m_active = 1'b1;
      m_start  = cyc;
    end
  endtask

  // One cycle, entered and left mid-cycle (at the falling edge).
  task automatic step(input logic s, input logic r, output outs_t got);
    outs_t e;
    if (r) begin
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
    end
    bus.in_strobe = s;
    #1;
    got = sample_dut();
    model_expect(e);
    check($sformatf("model_cyc%0d", cyc), 32'(got), 32'(e));
    model_advance(s);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t          tbl[14];
    outs_t         got;
    int            o1, o2, n_out, wr2;
    logic [AW-1:0] wrap_exp[8];
    logic [AW-1:0] wrap_seen[8];
    int            n_seen;

    // Single sample from a freshly reset pointer: strobe in cycle 0.
    tbl[0]  = '{in_strobe: 1'b1, exp: mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[2]  = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[3]  = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd15, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[4]  = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd14, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[5]  = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd13, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[6]  = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd12, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[7]  = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd11, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[8]  = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd10, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[9]  = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd9, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[10] = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd9, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[11] = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd9, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[12] = '{in_strobe: 1'b0, exp: mk(1'b1, 1'b0, 4'd0, 4'd9, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[13] = '{in_strobe: 1'b0, exp: mk(1'b0, 1'b0, 4'd0, 4'd9, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0)};

    wrap_exp[0] = 4'd2;  wrap_exp[1] = 4'd1;  wrap_exp[2] = 4'd0;  wrap_exp[3] = 4'd15;
    wrap_exp[4] = 4'd14; wrap_exp[5] = 4'd13; wrap_exp[6] = 4'd12; wrap_exp[7] = 4'd11;

    total = 0; bad = 0; cyc = 0;
    reset = 1'b1;
    bus.in_strobe = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    step(1'b0, 1'b0, got);
    check("reset_state", 32'(got), 32'(outs_t'('0)));

    // One full sample, then abort the next one mid-RUN with an async reset.
    step(1'b1, 1'b0, got);
    repeat (13) step(1'b0, 1'b0, got);
    step(1'b1, 1'b0, got);
    repeat (5) step(1'b0, 1'b0, got);
    step(1'b0, 1'b1, got);
    check("reset_mid_run", 32'(got), 32'(outs_t'('0)));
    n_out = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, got);
      if (got.out_strobe) n_out++;
    end
    check("no_out_after_reset", 32'(n_out), 32'd0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].in_strobe, 1'b0, got);
      check($sformatf("tbl_c%0d", i), 32'(got), 32'(tbl[i].exp));
    end

    // Back-to-back at minimum spacing from pointer 0.
    step(1'b0, 1'b1, got);
    o1 = -1; o2 = -1; n_out = 0; wr2 = -1;
    for (int c = 0; c < 27; c++) begin
      step((c == 0) || (c == 13), 1'b0, got);
      if (got.out_strobe) begin
        if (n_out == 0) o1 = c; else o2 = c;
        n_out++;
      end
      if (got.wr_en && c > 13) wr2 = int'(got.wr_addr);
    end
    check("b2b_out_count", 32'(n_out), 32'd2);
    check("b2b_first_out", 32'(o1), 32'd12);
    check("b2b_out_gap", 32'(o2 - o1), 32'd13);
    check("b2b_wr_addr2", 32'(wr2), 32'd1);
    check("b2b_overrun", 32'(got.overrun), 32'd0);

    // Overrun: a strobe in the middle of RUN is dropped.
    for (int c = 0; c < 14; c++) begin
      step((c == 0) || (c == 5), 1'b0, got);
      if (c == 5)  check("ovr_before", 32'(got.overrun), 32'd0);
      if (c == 6)  check("ovr_set", 32'(got.overrun), 32'd1);
      if (c == 12) check("ovr_result", 32'(got.out_strobe), 32'd1);
    end
    repeat (3) step(1'b0, 1'b0, got);
    check("ovr_sticky", 32'(got.overrun), 32'd1);

    // Pointer wrap: the 19th sample starts at wr_ptr = 2.
    step(1'b0, 1'b1, got);
    for (int s = 0; s < 18; s++) begin
      step(1'b1, 1'b0, got);
      repeat (12) step(1'b0, 1'b0, got);
    end
    n_seen = 0;
    for (int c = 0; c < 14; c++) begin
      step(c == 0, 1'b0, got);
      if (got.mac_en && n_seen < 8) begin
        wrap_seen[n_seen] = got.samp;
        n_seen++;
      end
    end
    check("wrap_mac_cycles", 32'(n_seen), 32'd8);
    for (int j = 0; j < 8; j++)
      check($sformatf("wrap_samp%0d", j), 32'(wrap_seen[j]), 32'(wrap_exp[j]));

    // Random strobes with occasional async resets, checked cycle by cycle.
    step(1'b0, 1'b1, got);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 6) == 0, $urandom_range(0, 399) == 0, got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Control FSM for a single-MAC FIR filter. On each input-sample strobe it does three things: writes the new sample into the circular delay-line RAM, then walks the coefficient-ROM address and the delay-line read address across all taps, then drives the MAC clear/enable controls. After the MAC pipeline drains it emits a result strobe. It sits between the sample source and the coefficient ROM / sample RAM / MAC datapath of the FIR.

Parameters:
NTAPS, 256, number of filter taps; must be >= 2 and <= 2**ADDR_W.
ADDR_W, 8, width of the coefficient and delay-line addresses; the delay line is 2**ADDR_W deep.
PIPE_LAT, 3, MAC pipeline depth in cycles from the last mac_en to a valid accumulator; must be >= 0.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
in_strobe  in  1  one-cycle pulse: a new sample is present on the RAM write-data bus.
busy  out  1  high while a sample is being processed.
wr_en  out  1  delay-line RAM write enable.
wr_addr  out  ADDR_W  delay-line RAM write address.
samp_addr  out  ADDR_W  delay-line RAM read address.
coef_addr  out  ADDR_W  coefficient ROM address.
mac_clr  out  1  accumulator load (the first product replaces the accumulator).
mac_en  out  1  accumulate enable.
out_strobe  out  1  one-cycle pulse: the accumulator holds a valid filter output.
overrun  out  1  sticky flag: an in_strobe arrived while busy.

Behaviour:
- All outputs are registered. Reset clears every output, wr_ptr, the tap counter and the flush counter to 0, and forces state IDLE. Reset mid-operation aborts the sample; no out_strobe is produced for it.
- Internal state: wr_ptr (ADDR_W bits, address of the newest sample), tap counter k, flush counter.
- FSM states: IDLE, LOAD, RUN, FLUSH, DONE. Timing below is relative to in_strobe sampled high in IDLE at edge 0.
- IDLE:
  - busy=0 and all strobes are 0.
  - in_strobe=1 moves the FSM to LOAD.
- LOAD (cycle 1):
  - wr_en=1, wr_addr=wr_ptr, busy=1.
  - Next state is RUN with k=0.
- RUN (cycles 2 .. NTAPS+1):
  - mac_en=1, coef_addr=k, samp_addr=(wr_ptr - k) mod 2**ADDR_W.
  - mac_clr=1 only when k=0.
  - k increments each cycle. After k=NTAPS-1 the next state is FLUSH, or DONE directly if PIPE_LAT=0.
- FLUSH:
  - mac_en=0 and the addresses hold their last values.
  - Lasts exactly PIPE_LAT cycles, then DONE.
- DONE (cycle NTAPS+2+PIPE_LAT):
  - out_strobe=1 for exactly one cycle.
  - wr_ptr increments mod 2**ADDR_W.
  - Next state is IDLE, where busy drops.
- Latency from in_strobe to out_strobe is NTAPS+2+PIPE_LAT cycles. The minimum sample spacing is NTAPS+3+PIPE_LAT cycles.
- busy=1 in LOAD, RUN, FLUSH and DONE.
- Overrun handling:
  - An in_strobe while busy (including in DONE) is ignored and sets overrun.
  - overrun stays set until reset.
  - The current sample completes normally.
- wr_en is high for exactly one cycle per accepted sample. mac_en is high for exactly NTAPS consecutive cycles. mac_clr is high for exactly one cycle, coincident with the first mac_en.
- Outside RUN, mac_en=0 and mac_clr=0. wr_addr, samp_addr and coef_addr hold their last values outside their active states.
- Address wrap: wr_ptr wraps from 2**ADDR_W-1 to 0, and samp_addr subtraction wraps modulo 2**ADDR_W.

Test Plan:
- Reset check (NTAPS=8, ADDR_W=4, PIPE_LAT=2): pulse reset async mid-cycle -> all outputs 0 immediately, busy=0, overrun=0.
- Single sample:
  - in_strobe at cycle 0 -> wr_en=1 with wr_addr=0 at cycle 1.
  - mac_en high cycles 2-9 with coef_addr 0..7 and samp_addr 0,15,14,13,12,11,10,9.
  - mac_clr only at cycle 2; out_strobe at cycle 12; busy low at cycle 13.
- Back-to-back at minimum spacing: strobes 13 cycles apart -> two out_strobes 13 cycles apart, second wr_addr=1, overrun=0.
- Overrun: second in_strobe at cycle 5 -> ignored, overrun=1 from cycle 6, first result still at cycle 12, overrun persists.
- Wrap: after 18 accepted samples, wr_ptr wraps to 2 -> the 19th sample's samp_addr sequence is 2,1,0,15,14,13,12,11.
- Reset mid-RUN: assert reset at cycle 6 -> outputs 0 immediately, no out_strobe, next sample writes wr_addr=0.
